// File: rtl/multi_centroid_pkg.sv
// ============================================================================
// Module : multi_centroid_pkg
// Brief  : Shared types and width helpers for the multi-channel centroid block.
//          Optional bbox fields follow MULTI_CENTROID_BBOX_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multi_centroid_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_X_W   = 11;
  localparam int DEF_Y_W   = 10;
  localparam int DEF_CNT_W = 20;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W    = ch_width(DEF_N_CH);
  localparam int SUM_X_W = DEF_X_W + DEF_CNT_W;
  localparam int SUM_Y_W = DEF_Y_W + DEF_CNT_W;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    LOAD   = 2'd1,
    DIVIDE = 2'd2,
    EMIT   = 2'd3
  } state_t;

  // Accumulator storage is sized from the default geometry above.
  typedef struct packed {
    logic [SUM_X_W-1:0]   sum_x;
    logic [SUM_Y_W-1:0]   sum_y;
    logic [DEF_CNT_W-1:0] count;
`ifdef MULTI_CENTROID_BBOX_EN
    logic [DEF_X_W-1:0]   x_min;
    logic [DEF_X_W-1:0]   x_max;
    logic [DEF_Y_W-1:0]   y_min;
    logic [DEF_Y_W-1:0]   y_max;
`endif
  } acc_t;

  function automatic acc_t acc_clear();
    acc_t a;
    a.sum_x = '0;
    a.sum_y = '0;
    a.count = '0;
`ifdef MULTI_CENTROID_BBOX_EN
    a.x_min = '1;
    a.x_max = '0;
    a.y_min = '1;
    a.y_max = '0;
`endif
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_centroid_seq_divider.sv
// ============================================================================
// Module : seq_divider
// Brief  : Restoring unsigned divider, one quotient bit per cycle, start/done
//          handshake. A zero divisor yields a zero quotient.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int W   = 31,
  parameter int Q_W = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_dividend,
  input  logic [W-1:0]   i_divisor,
  output logic [Q_W-1:0] o_quotient,
  output logic           o_done
);

  localparam int C_CNT_W = $clog2(W + 1);

  logic [W-1:0]       r_q;
  logic [W-1:0]       r_div;
  logic [W-1:0]       r_rem;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_done;
  logic               r_dz;

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  assign w_shift = {r_rem, r_q[W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_q   <= i_dividend;
        r_div <= i_divisor;
        r_rem <= '0;
        r_cnt <= C_CNT_W'(W);
        r_dz  <= (i_divisor == '0);
      end else if (r_cnt != '0) begin
        // Borrow clear means the trial subtraction succeeded.
        if (!w_diff[W]) begin
          r_rem <= w_diff[W-1:0];
          r_q   <= {r_q[W-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[W-1:0];
          r_q   <= {r_q[W-2:0], 1'b0};
        end
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == C_CNT_W'(1)) r_done <= 1'b1;
      end
    end
  end

  assign o_quotient = r_dz ? '0 : r_q[Q_W-1:0];
  assign o_done     = r_done;

endmodule

`default_nettype wire

// File: rtl/multi_centroid.sv
// ============================================================================
// Module : multi_centroid
// Brief  : Per-channel pixel sum/count accumulation with sequential division,
//          streaming one centroid per channel after each tabulate pulse.
//          Optional bounding box under MULTI_CENTROID_BBOX_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_centroid
  import multi_centroid_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_COUNT = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [X_W-1:0]            x_in,
  input  logic [Y_W-1:0]            y_in,
  input  logic [ch_width(N_CH)-1:0] ch_in,
  input  logic                      valid_in,
  input  logic                      tabulate_in,
  output logic                      busy_out,
  output logic                      valid_out,
  output logic [ch_width(N_CH)-1:0] ch_out,
  output logic [X_W-1:0]            x_out,
  output logic [Y_W-1:0]            y_out,
  output logic [CNT_W-1:0]          count_out,
  output logic                      found_out,
`ifdef MULTI_CENTROID_BBOX_EN
  output logic [X_W-1:0]            x_min_out,
  output logic [X_W-1:0]            x_max_out,
  output logic [Y_W-1:0]            y_min_out,
  output logic [Y_W-1:0]            y_max_out,
`endif
  output logic                      done_out
);

  localparam int               C_CH_W    = ch_width(N_CH);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t            r_state, w_next;
  acc_t              r_acc [N_CH];
  logic [C_CH_W-1:0] r_idx;
  logic              r_xdone, r_ydone;
  logic [CNT_W-1:0]  r_cnt;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
`ifdef MULTI_CENTROID_BBOX_EN
  logic [X_W-1:0]    r_xmin, r_xmax;
  logic [Y_W-1:0]    r_ymin, r_ymax;
`endif

  acc_t           w_cur, w_pix, w_upd;
  logic           w_start, w_last, w_pix_ok, w_emit;
  logic [X_W-1:0] w_qx;
  logic [Y_W-1:0] w_qy;
  logic           w_xdone, w_ydone;

  assign w_cur    = r_acc[r_idx];
  assign w_last   = (r_idx == C_CH_W'(N_CH - 1));
  assign w_pix_ok = valid_in && ({1'b0, ch_in} < (C_CH_W + 1)'(N_CH));

  always_comb begin
    w_pix       = r_acc[ch_in];
    w_upd       = w_pix;
    w_upd.sum_x = w_pix.sum_x + SUM_X_W'(x_in);
    w_upd.sum_y = w_pix.sum_y + SUM_Y_W'(y_in);
    w_upd.count = w_pix.count + 1'b1;
`ifdef MULTI_CENTROID_BBOX_EN
    if (x_in < w_pix.x_min) w_upd.x_min = x_in;
    if (x_in > w_pix.x_max) w_upd.x_max = x_in;
    if (y_in < w_pix.y_min) w_upd.y_min = y_in;
    if (y_in > w_pix.y_max) w_upd.y_max = y_in;
`endif
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ACCUM:  if (tabulate_in) w_next = LOAD;
      LOAD: begin
        if (w_cur.count == '0) begin
          w_next = EMIT;
        end else begin
          w_start = 1'b1;
          w_next  = DIVIDE;
        end
      end
      DIVIDE: if (r_xdone && r_ydone) w_next = EMIT;
      EMIT:   w_next = w_last ? ACCUM : LOAD;
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ACCUM;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_CH; i++) r_acc[i] <= acc_clear();
      r_idx   <= '0;
      r_xdone <= 1'b0;
      r_ydone <= 1'b0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
`ifdef MULTI_CENTROID_BBOX_EN
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
`endif
    end else begin
      case (r_state)
        ACCUM: begin
          // A saturated channel freezes sums too, keeping sum/count consistent.
          if (w_pix_ok && (w_pix.count != C_CNT_MAX)) r_acc[ch_in] <= w_upd;
          r_idx <= '0;
        end
        LOAD: begin
          r_xdone <= 1'b0;
          r_ydone <= 1'b0;
          r_cnt   <= w_cur.count;
          r_x     <= '0;
          r_y     <= '0;
`ifdef MULTI_CENTROID_BBOX_EN
          if (w_cur.count == '0) begin
            r_xmin <= '0;
            r_xmax <= '0;
            r_ymin <= '0;
            r_ymax <= '0;
          end else begin
            r_xmin <= w_cur.x_min;
            r_xmax <= w_cur.x_max;
            r_ymin <= w_cur.y_min;
            r_ymax <= w_cur.y_max;
          end
`endif
        end
        DIVIDE: begin
          if (w_xdone) begin
            r_xdone <= 1'b1;
            r_x     <= w_qx;
          end
          if (w_ydone) begin
            r_ydone <= 1'b1;
            r_y     <= w_qy;
          end
        end
        EMIT: begin
          r_acc[r_idx] <= acc_clear();
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  seq_divider #(.W(SUM_X_W), .Q_W(X_W)) u_div_x (
    .clk        (clk_in),
    .rst        (rst_in),
    .i_start    (w_start),
    .i_dividend (w_cur.sum_x),
    .i_divisor  (SUM_X_W'(w_cur.count)),
    .o_quotient (w_qx),
    .o_done     (w_xdone)
  );

  seq_divider #(.W(SUM_Y_W), .Q_W(Y_W)) u_div_y (
    .clk        (clk_in),
    .rst        (rst_in),
    .i_start    (w_start),
    .i_dividend (w_cur.sum_y),
    .i_divisor  (SUM_Y_W'(w_cur.count)),
    .o_quotient (w_qy),
    .o_done     (w_ydone)
  );

  // Strobes are suppressed during the reset cycle so an abort emits nothing.
  assign w_emit    = (r_state == EMIT) && !rst_in;
  assign busy_out  = (r_state != ACCUM) && !rst_in;
  assign valid_out = w_emit;
  assign done_out  = w_emit && w_last;
  assign ch_out    = r_idx;
  assign x_out     = r_x;
  assign y_out     = r_y;
  assign count_out = r_cnt;
  assign found_out = (r_cnt >= CNT_W'(MIN_COUNT));
`ifdef MULTI_CENTROID_BBOX_EN
  assign x_min_out = r_xmin;
  assign x_max_out = r_xmax;
  assign y_min_out = r_ymin;
  assign y_max_out = r_ymax;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_centroid.sv
// ============================================================================
// Module : tb_multi_centroid
// Brief  : Directed self-checking bench for multi_centroid (default geometry).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_centroid;

  localparam int N_CH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic [1:0]  ch = '0;
  logic        vin = 1'b0;
  logic        tab = 1'b0;
  logic        busy_out, valid_out, found_out, done_out;
  logic [1:0]  ch_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [19:0] count_out;
`ifdef MULTI_CENTROID_BBOX_EN
  logic [10:0] x_min_out, x_max_out;
  logic [9:0]  y_min_out, y_max_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_centroid dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .x_in        (x),
    .y_in        (y),
    .ch_in       (ch),
    .valid_in    (vin),
    .tabulate_in (tab),
    .busy_out    (busy_out),
    .valid_out   (valid_out),
    .ch_out      (ch_out),
    .x_out       (x_out),
    .y_out       (y_out),
    .count_out   (count_out),
    .found_out   (found_out),
`ifdef MULTI_CENTROID_BBOX_EN
    .x_min_out   (x_min_out),
    .x_max_out   (x_max_out),
    .y_min_out   (y_min_out),
    .y_max_out   (y_max_out),
`endif
    .done_out    (done_out)
  );

  typedef struct { int frame; int ch; int x0; int xstep; int y; int n; } burst_t;
  typedef struct { int x; int y; int cnt; bit found; } res_t;

  burst_t bursts [5];
  res_t   tbl [12];
  res_t   exp_cur [N_CH];

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic pix(input int c, input int px, input int py);
    ch = 2'(c); x = 11'(px); y = 10'(py); vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic tabulate();
    tab = 1'b1;
    @(negedge clk);
    tab = 1'b0;
  endtask

  task automatic set_zero_exp();
    for (int c = 0; c < N_CH; c++) exp_cur[c] = '{0, 0, 0, 1'b0};
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    int t = 0;
    while (valid_out !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 3000);
    if (!ok) chk({tag, " timeout"}, 0, 1);
  endtask

  task automatic collect(input string tag);
    bit ok;
    for (int k = 0; k < N_CH; k++) begin
      wait_valid(tag, ok);
      if (!ok) return;
      chk({tag, " ch"},    ch_out,    k);
      chk({tag, " x"},     x_out,     exp_cur[k].x);
      chk({tag, " y"},     y_out,     exp_cur[k].y);
      chk({tag, " count"}, count_out, exp_cur[k].cnt);
      chk({tag, " found"}, found_out, exp_cur[k].found);
      chk({tag, " done"},  done_out,  (k == N_CH - 1) ? 1 : 0);
      @(negedge clk);
    end
    chk({tag, " busy low after done"}, busy_out, 0);
    chk({tag, " strobe one cycle"},    valid_out, 0);
  endtask

  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (valid_out === 1'b1 || done_out === 1'b1) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_extra;
    bit ok;

    bursts[0] = '{0, 0, 100,  0, 50,   20};
    bursts[1] = '{0, 2, 640,  0, 360,  16};
    bursts[2] = '{1, 1, 0,    1, 7,    10};
    bursts[3] = '{2, 0, 2047, 0, 0,    17};
    bursts[4] = '{2, 3, 0,    1, 1023, 16};

    tbl[0]  = '{100, 50, 20, 1'b1};
    tbl[1]  = '{0, 0, 0, 1'b0};
    tbl[2]  = '{640, 360, 16, 1'b1};
    tbl[3]  = '{0, 0, 0, 1'b0};
    tbl[4]  = '{0, 0, 0, 1'b0};
    tbl[5]  = '{4, 7, 10, 1'b0};
    tbl[6]  = '{0, 0, 0, 1'b0};
    tbl[7]  = '{0, 0, 0, 1'b0};
    tbl[8]  = '{2047, 0, 17, 1'b1};
    tbl[9]  = '{0, 0, 0, 1'b0};
    tbl[10] = '{0, 0, 0, 1'b0};
    tbl[11] = '{7, 1023, 16, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset valid_out", valid_out, 0);
    chk("reset busy_out",  busy_out,  0);
    chk("reset done_out",  done_out,  0);
    chk("reset count_out", count_out, 0);
    chk("reset x_out",     x_out,     0);
    rst = 1'b0;
    @(negedge clk);

    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 5; b++)
        if (bursts[b].frame == f)
          for (int i = 0; i < bursts[b].n; i++)
            pix(bursts[b].ch, bursts[b].x0 + i * bursts[b].xstep, bursts[b].y);
      tabulate();
      chk("busy after tabulate", busy_out, 1);
      for (int c = 0; c < N_CH; c++) exp_cur[c] = tbl[f * N_CH + c];
      collect($sformatf("frame%0d", f));
    end

    // Last pixel coincides with tabulate.
    for (int i = 0; i < 15; i++) pix(0, 1, 1);
    ch = 2'd0; x = 11'd1; y = 10'd1; vin = 1'b1; tab = 1'b1;
    @(negedge clk);
    vin = 1'b0; tab = 1'b0;
    set_zero_exp();
    exp_cur[0] = '{1, 1, 16, 1'b1};
    collect("coincident");

    // Pixels and a second tabulate during busy are dropped.
    for (int i = 0; i < 16; i++) pix(0, 2, 3);
    tabulate();
    chk("busy during frame", busy_out, 1);
    for (int i = 0; i < 5; i++) pix(1, 9, 9);
    tabulate();
    set_zero_exp();
    exp_cur[0] = '{2, 3, 16, 1'b1};
    collect("busy_drop");
    count_strobes(150, n_extra);
    chk("no extra strobes after frame", n_extra, 0);
    tabulate();
    set_zero_exp();
    collect("after_busy_empty");

    // Reset while ch1 is dividing.
    for (int i = 0; i < 16; i++) pix(0, 4, 4);
    for (int i = 0; i < 20; i++) pix(1, 7, 7);
    tabulate();
    wait_valid("reset_seq ch0", ok);
    if (ok) begin
      chk("reset_seq first ch", ch_out, 0);
      repeat (6) @(negedge clk);
      chk("reset_seq busy before abort", busy_out, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_seq busy after abort", busy_out, 0);
      count_strobes(300, n_extra);
      chk("reset_seq no strobes", n_extra, 0);
      for (int i = 0; i < 16; i++) pix(3, 5, 5);
      tabulate();
      set_zero_exp();
      exp_cur[3] = '{5, 5, 16, 1'b1};
      collect("after_reset");
    end

`ifdef MULTI_CENTROID_BBOX_EN
    pix(0, 10, 20);
    pix(0, 30, 5);
    tabulate();
    wait_valid("bbox ch0", ok);
    if (ok) begin
      chk("bbox x",     x_out,     20);
      chk("bbox y",     y_out,     12);
      chk("bbox count", count_out, 2);
      chk("bbox x_min", x_min_out, 10);
      chk("bbox x_max", x_max_out, 30);
      chk("bbox y_min", y_min_out, 5);
      chk("bbox y_max", y_max_out, 20);
      @(negedge clk);
      wait_valid("bbox ch1", ok);
      if (ok) begin
        chk("bbox empty x_min", x_min_out, 0);
        chk("bbox empty y_max", y_max_out, 0);
        while (done_out !== 1'b1) begin
          @(negedge clk);
          wait_valid("bbox drain", ok);
          if (!ok) break;
        end
        @(negedge clk);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_centroid.md
Name: multi_centroid

Overview:
- Parametrised successor to the single-object centre-of-mass block.
- Accumulates pixel sums and counts for N_CH independent channels, e.g. colour classes from the mask stage.
- On a tabulate pulse, divides each channel in turn and streams one centroid result per channel, tagged with its channel index.
- Channels with too few pixels are reported as not found. Sits between pixel masking and the game-logic/slice-detection stage.

Parameters:
N_CH, 4, number of tracked channels (>=1)
X_W, 11, x coordinate width
Y_W, 10, y coordinate width
CNT_W, 20, per-channel pixel count width (saturating)
MIN_COUNT, 16, minimum count for found_out=1

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset
x_in  in  X_W  pixel x
y_in  in  Y_W  pixel y
ch_in  in  $clog2(N_CH) (min 1)  channel of pixel
valid_in  in  1  pixel strobe
tabulate_in  in  1  end-of-frame pulse, starts computation
busy_out  out  1  high from tabulate accept until done_out
valid_out  out  1  one-cycle result strobe
ch_out  out  $clog2(N_CH)  channel of current result
x_out  out  X_W  centroid x (truncated quotient)
y_out  out  Y_W  centroid y
count_out  out  CNT_W  pixel count of channel
found_out  out  1  count_out >= MIN_COUNT
done_out  out  1  one-cycle pulse after last channel emitted

Behaviour:
- Interface: one clock, clk_in; rst_in is synchronous, active-high.
- Reset: all outputs 0; all accumulators 0; FSM in ACCUM.
- Accumulator widths: x sum X_W+CNT_W, y sum Y_W+CNT_W. No overflow is possible while count is unsaturated.
- Count saturation: once count reaches 2^CNT_W-1, further pixels on that channel are ignored for count and sums alike, so the ratio stays consistent.
- FSM states:
  - ACCUM: valid_in adds x_in/y_in to channel ch_in and increments its count. ch_in >= N_CH is dropped. tabulate_in moves to LOAD with channel index 0 and raises busy_out the next cycle.
  - Simultaneous valid_in and tabulate_in: the pixel is accumulated first, then the transition occurs.
  - LOAD: if count == 0, skip division and go to EMIT with x/y = 0. Otherwise start both dividers with the channel's sums and count, then go to DIVIDE.
  - DIVIDE: wait until both divider done flags are captured. The dividers may finish in different cycles, so each flag is sticky until LOAD.
  - EMIT: valid_out=1 for exactly one cycle with ch_out, x_out, y_out, count_out, found_out. Then clear that channel's accumulators.
    - Not last channel: increment index, go to LOAD.
    - Last channel: pulse done_out in the same cycle as the final valid_out, drop busy_out the next cycle, return to ACCUM.
- While busy_out=1: valid_in and tabulate_in are ignored. Dropped pixels are not buffered.
- Results are emitted in ascending channel order, N_CH strobes per tabulate, never back-to-back faster than one per LOAD+DIVIDE+EMIT.
- Latency per channel: 1 (LOAD) + divider latency (SUM_W+2 cycles) + 1 (EMIT). A zero-count channel takes 2 cycles.
- Divider quotients are truncated to X_W/Y_W. A quotient always fits, since each sum divided by its count is at most the max coordinate.
- rst_in mid-DIVIDE/EMIT: abort immediately. No valid_out or done_out; dividers reset; accumulators cleared.

Optional Feature:
- Macro: MULTI_CENTROID_BBOX_EN.
- Defined: each channel also tracks x_min, x_max, y_min, y_max.
  - Reset/clear values: min = all-ones, max = 0.
  - Added outputs x_min_out, x_max_out (X_W) and y_min_out, y_max_out (Y_W) are valid with valid_out.
  - The bbox is 0 for a zero-count channel.
- Undefined: no bbox registers or ports exist.

Decomposition:
- Package multi_centroid_pkg holds:
  - the state enum (ACCUM, LOAD, DIVIDE, EMIT);
  - width helper localparams (SUM_X_W, SUM_Y_W, CH_W);
  - a packed struct for per-channel accumulator contents.
- One sub-module, seq_divider: parametrised width, restoring, start/done handshake, one bit per cycle, divide-by-zero yields quotient 0. Instantiated twice, for x and y.

Test Plan:
- Channel 0 gets 20 pixels at (100,50), channel 2 gets 16 at (640,360), then tabulate. Required: 4 valid_out in order ch 0..3.
  - ch0: (100,50), count 20, found 1.
  - ch1 and ch3: count 0, found 0, x/y = 0.
  - ch2: (640,360), found 1.
  - done_out coincides with ch3.
- Channel 1 gets 10 pixels with x 0..9, y=7. Required: x_out 4 (45/10 truncated), y_out 7, found 0 (10<16).
- tabulate_in coincident with the last pixel (1,1) on ch0 after 15 pixels at (1,1). Required: count_out 16, found 1.
- Pixels and a second tabulate sent during busy_out. Required: both ignored. The next frame starts from zero sums, and exactly N_CH results are produced.
- rst_in asserted during DIVIDE of ch1. Required: no further valid_out or done_out. A new frame with 16 pixels at (5,5) on ch3 reports only that data.
- With MULTI_CENTROID_BBOX_EN: ch0 pixels (10,20) and (30,5). Required: bbox x 10..30, y 5..20, centroid (20,12).
